spi_memrd: RTL and testbench
============================

Name: spi_memrd

Overview:
- SPI-to-PSRAM read streamer; the read-side counterpart of spi_memwr. It sits on the spi_dev_proto pw_* bus and on one memif_arb downstream port.
- On a read command it captures a 24-bit word address and prefetches 16-bit words from PSRAM in bursts into a small FIFO.
- It returns the data byte by byte on the protocol response path until the SPI transaction ends.
- A 4-register Wishbone CSR block provides enable, burst length and status.

Parameters:
- CMD_CODE, 8'hF9: command byte that starts a read transaction.
- FIFO_LOG2, 3: log2 of prefetch FIFO depth, in 16-bit words.
- MAX_BURST, 8: largest allowed burst length in words; must be ≤ 2**FIFO_LOG2 and ≤ 128.

Ports:
- clk  in  1  system clock (clk_1x domain)
- rst_n  in  1  asynchronous active-low reset
- pw_wdata  in  8  command/data byte from protocol wrapper
- pw_wcmd  in  1  pw_wdata is a command byte
- pw_wstb  in  1  pw_wdata valid
- pw_end  in  1  SPI transaction ended (CS rise)
- pw_req  in  1  protocol wrapper requests next response byte
- pw_gnt  out  1  this block owns the response path for the current command
- pw_rdata  out  8  response byte
- pw_rstb  out  1  pw_rdata valid
- mi_addr  out  32  word address; [31:24] always 0
- mi_len  out  7  burst length minus one
- mi_rw  out  1  1 = read; constant 1
- mi_valid  out  1  request valid
- mi_ready  in  1  request accepted
- mi_wdata  out  16  constant 0
- mi_wack  in  1  ignored
- mi_wlast  in  1  ignored
- mi_rdata  in  16  read data word
- mi_rstb  in  1  read data valid
- mi_rlast  in  1  last word of burst
- wb_wdata  in  32  CSR write data
- wb_rdata  out  32  CSR read data
- wb_addr  in  2  CSR select
- wb_we  in  1  write enable
- wb_cyc  in  1  cycle strobe
- wb_ack  out  1  acknowledge

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except mi_rw=1 and mi_wdata=0. FSM goes to IDLE, FIFO is emptied, CSR burst length is MAX_BURST, enable is 0, underrun is 0.
- CSR map (ack exactly 1 cycle after wb_cyc, deasserted the next cycle; wb_rdata is 0 when not acked):
  - reg0 CTRL: bit0 enable (RW); bit1 busy (RO, FSM≠IDLE); bit2 underrun (sticky, write-1-to-clear).
  - reg1 BLEN: bits[7:0] burst length in words. Writes are clamped to the range 1..MAX_BURST.
  - reg2 ADDR: RO, current fetch address [23:0].
  - reg3: reads 0.
- FSM states: IDLE, ADDR0, ADDR1, ADDR2, STREAM, DRAIN.
- IDLE → ADDR0 on pw_wstb & pw_wcmd & pw_wdata==CMD_CODE & enable. Any other command is ignored.
- ADDRn: each pw_wstb with !pw_wcmd shifts in one address byte, MSB first. After the third byte, the state goes to STREAM and pw_gnt=1.
- STREAM prefetch:
  - When no burst is outstanding and FIFO free ≥ BLEN, assert mi_valid with mi_addr = fetch address and mi_len = BLEN-1.
  - Hold all mi_* stable until mi_ready. On mi_ready, mark the burst outstanding and add BLEN to the fetch address, wrapping modulo 2^24.
  - Each mi_rstb pushes mi_rdata into the FIFO. mi_rstb&mi_rlast clears outstanding.
  - FIFO space is reserved at request time, so the FIFO never overflows.
- STREAM output:
  - pw_req seen at cycle N → pw_rstb=1 for exactly one cycle at N+1.
  - Each FIFO word is emitted as the low byte, then the high byte. The pop happens after the high byte.
  - If the FIFO is empty at pw_req, send 0x00, set underrun, and do not advance the byte phase.
- pw_end in any non-IDLE state:
  - pw_gnt drops the next cycle and the FIFO is flushed.
  - Outstanding burst or mi_valid pending → DRAIN. The request is held until mi_ready; incoming words are discarded until mi_rlast; then IDLE.
  - Otherwise → IDLE.
- Simultaneous events:
  - pw_end has priority over pw_req and over a new command in the same cycle.
  - A FIFO push and pop in the same cycle is legal and the count is unchanged.
- Clearing enable mid-transaction does not abort it; it only blocks new commands.
- Reset mid-burst abandons the memif transaction. The arbiter is on the same reset.

Decomposition:
- Shared package (spi_memrd_pkg): FSM state encoding, CSR offsets, CTRL bit positions, CMD_CODE default.
- One sub-module, spi_memrd_fifo: synchronous FIFO, 16 bits wide, 2**FIFO_LOG2 deep, with push/pop/empty/level. Level drives the free-space check.

Test Plan:
- Basic read: memory words 0x1234, 0xABCD at word addr 0x000010, BLEN=2, cmd F9 00 00 10, then 4 pw_req → bytes 34 12 CD AB; mi_addr=0x10 with mi_len=1 first, next request at 0x12.
- Address wrap: start addr 0xFFFFFE, BLEN=2, 6 pw_req → second burst mi_addr=0x000000; reg2 reads 0x000002.
- Underrun: arbiter holds mi_ready low, pw_req issued → pw_rdata=0x00, CTRL bit2=1. Writing 0x4 to reg0 clears it.
- Abort mid-burst: pw_end after 2 of 8 words received → DRAIN until mi_rlast, then IDLE; busy=0; FIFO empty; next command behaves normally.
- Disabled / wrong command: enable=0 with cmd F9, or enable=1 with cmd F8 → no mi_valid, pw_gnt stays 0.
- CSR: write BLEN=200 → reads back MAX_BURST (8). Write 0 → reads 1. wb_ack is a single-cycle pulse.

Source files
------------

// File: rtl/spi_memrd_pkg.sv
// spi_memrd shared definitions
// FSM encoding, CSR map and helpers
package spi_memrd_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR0  = 3'd1;
  localparam logic [2:0] S_ADDR1  = 3'd2;
  localparam logic [2:0] S_ADDR2  = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  localparam logic [1:0] CSR_CTRL = 2'd0;
  localparam logic [1:0] CSR_BLEN = 2'd1;
  localparam logic [1:0] CSR_ADDR = 2'd2;
  localparam logic [1:0] CSR_RSVD = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_BUSY = 1;
  localparam int CTRL_UNDR = 2;

  localparam logic [7:0] CMD_DEFAULT = 8'hF9;

  function automatic logic [7:0] clamp_blen(
    input logic [7:0] v,
    input logic [7:0] maxb
  );
    if (v == 8'd0)
      return 8'd1;
    else if (v > maxb)
      return maxb;
    else
      return v;
  endfunction

endpackage

// File: rtl/spi_memrd_if.sv
// spi_memrd memif downstream bus
// master = streamer, slave = arbiter port
interface spi_memrd_if;
  logic [31:0] mi_addr;
  logic [6:0]  mi_len;
  logic        mi_rw;
  logic        mi_valid;
  logic        mi_ready;
  logic [15:0] mi_wdata;
  logic        mi_wack;
  logic        mi_wlast;
  logic [15:0] mi_rdata;
  logic        mi_rstb;
  logic        mi_rlast;

  modport master (
    output mi_addr, mi_len, mi_rw,
    output mi_valid, mi_wdata,
    input  mi_ready, mi_wack, mi_wlast,
    input  mi_rdata, mi_rstb, mi_rlast
  );

  modport slave (
    input  mi_addr, mi_len, mi_rw,
    input  mi_valid, mi_wdata,
    output mi_ready, mi_wack, mi_wlast,
    output mi_rdata, mi_rstb, mi_rlast
  );
endinterface

// File: rtl/spi_memrd_fifo.sv
// spi_memrd prefetch FIFO
// 16-bit words, show-ahead head, sync flush
module spi_memrd_fifo #(
  parameter int LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [15:0]   din,
  input  logic          pop,
  output logic [15:0]   dout,
  output logic          empty,
  output logic [LOG2:0] level
);
  localparam int DEPTH = 2**LOG2;

  logic [15:0]   mem [DEPTH];
  logic [LOG2-1:0] wp;
  logic [LOG2-1:0] rp;
  logic [LOG2:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (cnt != (LOG2+1)'(DEPTH));
  assign do_pop  = pop && (cnt != '0);
  assign dout    = mem[rp];
  assign empty   = (cnt == '0);
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wp <= wp + 1'b1;
      if (do_pop)
        rp <= rp + 1'b1;
      cnt <= cnt
           + (LOG2+1)'(do_push)
           - (LOG2+1)'(do_pop);
    end
  end

endmodule

// File: rtl/spi_memrd.sv
// spi_memrd: SPI-to-PSRAM read streamer
// prefetches bursts into a FIFO, returns bytes
module spi_memrd
  import spi_memrd_pkg::*;
#(
  parameter logic [7:0] CMD_CODE  = CMD_DEFAULT,
  parameter int         FIFO_LOG2 = 3,
  parameter int         MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pw_wdata,
  input  logic        pw_wcmd,
  input  logic        pw_wstb,
  input  logic        pw_end,
  input  logic        pw_req,
  output logic        pw_gnt,
  output logic [7:0]  pw_rdata,
  output logic        pw_rstb,
  spi_memrd_if.master mi,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic [1:0]  wb_addr,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack
);
  localparam int         DEPTH = 2**FIFO_LOG2;
  localparam logic [7:0] MAXB  = 8'(MAX_BURST);

  logic [2:0]  state;
  logic [23:0] addr_sr;
  logic [23:0] fetch_addr;
  logic        outstanding;
  logic        phase;
  logic        enable;
  logic        underrun;
  logic [7:0]  blen;

  logic        push;
  logic        pop;
  logic        flush;
  logic        empty;
  logic [15:0] head;
  logic [FIFO_LOG2:0] level;
  logic [31:0] free_w;

  logic        end_evt;
  logic        streaming;
  logic        accept;
  logic        last_word;
  logic        can_req;
  logic        req_evt;
  logic        cmd_hit;
  logic        addr_byte;
  logic        drain_need;
  logic        csr_go;
  logic [31:0] csr_val;
  logic        unused_in;

  assign end_evt   = pw_end && (state != S_IDLE);
  assign streaming = (state == S_STREAM) && !end_evt;
  assign accept    = mi.mi_valid && mi.mi_ready;
  assign last_word = mi.mi_rstb && mi.mi_rlast;
  assign free_w    = 32'(DEPTH) - 32'(level);
  assign can_req   = streaming && !outstanding
                  && !mi.mi_valid
                  && (free_w >= 32'(blen));
  assign req_evt   = streaming && pw_req;
  assign push      = streaming && outstanding
                  && mi.mi_rstb;
  assign pop       = req_evt && !empty && phase;
  assign flush     = end_evt;
  assign cmd_hit   = (state == S_IDLE) && pw_wstb
                  && pw_wcmd && enable
                  && (pw_wdata == CMD_CODE);
  assign addr_byte = pw_wstb && !pw_wcmd;
  assign drain_need = mi.mi_valid
                   || (outstanding && !last_word);
  assign csr_go    = wb_cyc && !wb_ack;

  assign mi.mi_rw    = 1'b1;
  assign mi.mi_wdata = '0;

  assign unused_in = &{1'b0, wb_wdata[31:8],
                       mi.mi_wack, mi.mi_wlast};

  spi_memrd_fifo #(
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (mi.mi_rdata),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_sr <= '0;
      pw_gnt  <= 1'b0;
    end else if (end_evt) begin
      pw_gnt <= 1'b0;
      state  <= drain_need ? S_DRAIN : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:
          if (cmd_hit)
            state <= S_ADDR0;
        S_ADDR0, S_ADDR1:
          if (addr_byte) begin
            addr_sr <= {addr_sr[15:0], pw_wdata};
            state   <= state + 3'd1;
          end
        S_ADDR2:
          if (addr_byte) begin
            state  <= S_STREAM;
            pw_gnt <= 1'b1;
          end
        S_DRAIN:
          if (outstanding && last_word)
            state <= S_IDLE;
        default: ;
      endcase
    end
  end

  // one burst in flight; FIFO room is checked before asking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mi.mi_valid <= 1'b0;
      mi.mi_addr  <= '0;
      mi.mi_len   <= '0;
      outstanding <= 1'b0;
      fetch_addr  <= '0;
    end else begin
      if ((state == S_ADDR2) && addr_byte && !end_evt)
        fetch_addr <= {addr_sr[15:0], pw_wdata};
      if (can_req) begin
        mi.mi_valid <= 1'b1;
        mi.mi_addr  <= {8'h00, fetch_addr};
        mi.mi_len   <= 7'(blen - 8'd1);
      end
      if (accept) begin
        mi.mi_valid <= 1'b0;
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr
                     + 24'(mi.mi_len) + 24'd1;
      end else if (last_word) begin
        outstanding <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_rstb  <= 1'b0;
      pw_rdata <= '0;
      phase    <= 1'b0;
    end else begin
      pw_rstb  <= req_evt;
      pw_rdata <= '0;
      if (req_evt && !empty) begin
        pw_rdata <= phase ? head[15:8] : head[7:0];
        phase    <= ~phase;
      end
      if (flush)
        phase <= 1'b0;
    end
  end

  always_comb begin
    csr_val = '0;
    unique case (wb_addr)
      CSR_CTRL: begin
        csr_val[CTRL_EN]   = enable;
        csr_val[CTRL_BUSY] = (state != S_IDLE);
        csr_val[CTRL_UNDR] = underrun;
      end
      CSR_BLEN: csr_val[7:0]  = blen;
      CSR_ADDR: csr_val[23:0] = fetch_addr;
      CSR_RSVD: csr_val = '0;
      default:  csr_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
      enable   <= 1'b0;
      blen     <= MAXB;
      underrun <= 1'b0;
    end else begin
      wb_ack   <= csr_go;
      wb_rdata <= '0;
      if (csr_go && !wb_we)
        wb_rdata <= csr_val;
      if (csr_go && wb_we && wb_addr == CSR_CTRL)
        enable <= wb_wdata[CTRL_EN];
      if (csr_go && wb_we && wb_addr == CSR_BLEN)
        blen <= clamp_blen(wb_wdata[7:0], MAXB);
      if (req_evt && empty)
        underrun <= 1'b1;
      else if (csr_go && wb_we
               && wb_addr == CSR_CTRL
               && wb_wdata[CTRL_UNDR])
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_memrd.sv
// spi_memrd directed bench
// arbiter model plus hand-computed byte streams
module tb_spi_memrd;
  import spi_memrd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pw_wdata;
  logic        pw_wcmd;
  logic        pw_wstb;
  logic        pw_end;
  logic        pw_req;
  logic        pw_gnt;
  logic [7:0]  pw_rdata;
  logic        pw_rstb;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic [1:0]  wb_addr;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  spi_memrd_if mi ();

  spi_memrd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pw_wdata (pw_wdata),
    .pw_wcmd  (pw_wcmd),
    .pw_wstb  (pw_wstb),
    .pw_end   (pw_end),
    .pw_req   (pw_req),
    .pw_gnt   (pw_gnt),
    .pw_rdata (pw_rdata),
    .pw_rstb  (pw_rstb),
    .mi       (mi),
    .wb_wdata (wb_wdata),
    .wb_rdata (wb_rdata),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nreq = 0;
  int nwords = 0;
  int grant_cap = 1000000;
  int gap = 0;
  logic [31:0] req_addr [$];
  logic [6:0]  req_len [$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word(logic [23:0] a);
    case (a)
      24'h000010: return 16'h1234;
      24'h000011: return 16'hABCD;
      default:    return {a[7:0] + 8'h10, a[7:0]};
    endcase
  endfunction

  // arbiter: one-cycle ready, then one word per gap+1 cycles
  initial begin : model
    int left;
    int gcnt;
    logic [23:0] cur;
    bit busy;
    busy = 0;
    left = 0;
    gcnt = 0;
    cur = '0;
    mi.mi_ready = 0;
    mi.mi_rstb = 0;
    mi.mi_rlast = 0;
    mi.mi_rdata = '0;
    mi.mi_wack = 0;
    mi.mi_wlast = 0;
    forever begin
      @(negedge clk);
      mi.mi_ready = 0;
      mi.mi_rstb = 0;
      mi.mi_rlast = 0;
      if (!rst_n) begin
        busy = 0;
      end else if (busy) begin
        if (gcnt > 0) begin
          gcnt--;
        end else begin
          mi.mi_rstb = 1;
          mi.mi_rdata = word(cur);
          mi.mi_rlast = (left == 0);
          cur++;
          nwords++;
          gcnt = gap;
          if (left == 0) busy = 0;
          else left--;
        end
      end else if (mi.mi_valid && nreq < grant_cap) begin
        mi.mi_ready = 1;
        req_addr.push_back(mi.mi_addr);
        req_len.push_back(mi.mi_len);
        nreq++;
        busy = 1;
        cur = mi.mi_addr[23:0];
        left = int'(mi.mi_len);
        gcnt = 0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(bit c, logic [7:0] d);
    pw_wcmd = c;
    pw_wdata = d;
    pw_wstb = 1;
    @(negedge clk);
    pw_wstb = 0;
    pw_wcmd = 0;
  endtask

  task automatic cmd(logic [7:0] code, logic [23:0] a);
    send(1, code);
    send(0, a[23:16]);
    send(0, a[15:8]);
    send(0, a[7:0]);
  endtask

  task automatic end_txn();
    pw_end = 1;
    @(negedge clk);
    pw_end = 0;
  endtask

  task automatic rd_byte(string tag, logic [7:0] exp);
    pw_req = 1;
    @(negedge clk);
    pw_req = 0;
    chk({tag, "_stb"}, 32'(pw_rstb), 1);
    chk(tag, 32'(pw_rdata), 32'(exp));
    @(negedge clk);
    chk({tag, "_1cy"}, 32'(pw_rstb), 0);
  endtask

  task automatic wb_go(logic [1:0] a, logic [31:0] d,
                       bit we, output logic [31:0] rd);
    wb_addr = a;
    wb_wdata = d;
    wb_we = we;
    wb_cyc = 1;
    @(negedge clk);
    for (int k = 0; k < 8 && !wb_ack; k++)
      @(negedge clk);
    chk("wb_ack", 32'(wb_ack), 1);
    rd = wb_rdata;
    wb_cyc = 0;
    wb_we = 0;
    @(negedge clk);
    chk("wb_ack_pulse", 32'(wb_ack), 0);
  endtask

  task automatic csr_wr(logic [1:0] a, logic [31:0] d);
    logic [31:0] rd;
    wb_go(a, d, 1, rd);
  endtask

  task automatic csr_chk(string tag, logic [1:0] a,
                         logic [31:0] exp);
    logic [31:0] rd;
    wb_go(a, 32'h0, 0, rd);
    chk(tag, rd, exp);
    chk({tag, "_idle"}, wb_rdata, 0);
  endtask

  task automatic wait_req(int n);
    for (int k = 0; k < 200 && nreq < n; k++)
      @(negedge clk);
    chk("req_cnt", 32'(nreq >= n), 1);
  endtask

  task automatic wait_words(int n);
    for (int k = 0; k < 400 && nwords < n; k++)
      @(negedge clk);
    chk("word_cnt", 32'(nwords >= n), 1);
  endtask

  initial begin
    int base;
    int wbase;
    pw_wdata = '0;
    pw_wcmd = 0;
    pw_wstb = 0;
    pw_end = 0;
    pw_req = 0;
    wb_wdata = '0;
    wb_addr = '0;
    wb_we = 0;
    wb_cyc = 0;
    cyc(3);
    chk("rst_rw", 32'(mi.mi_rw), 1);
    rst_n = 1;
    cyc(1);
    chk("rst_gnt", 32'(pw_gnt), 0);
    chk("rst_rstb", 32'(pw_rstb), 0);
    chk("rst_rdata", 32'(pw_rdata), 0);
    chk("rst_valid", 32'(mi.mi_valid), 0);
    chk("rst_addr", mi.mi_addr, 0);
    chk("rst_len", 32'(mi.mi_len), 0);
    chk("rst_wdata", 32'(mi.mi_wdata), 0);
    chk("rst_ack", 32'(wb_ack), 0);
    chk("rst_wbrd", wb_rdata, 0);
    csr_chk("rst_blen", CSR_BLEN, 8);
    csr_chk("rst_ctrl", CSR_CTRL, 0);
    csr_chk("rst_reg2", CSR_ADDR, 0);

    csr_wr(CSR_BLEN, 200);
    csr_chk("blen_hi", CSR_BLEN, 8);
    csr_wr(CSR_BLEN, 0);
    csr_chk("blen_lo", CSR_BLEN, 1);
    csr_wr(CSR_RSVD, 32'hFFFF_FFFF);
    csr_chk("reg3", CSR_RSVD, 0);

    cmd(8'hF9, 24'h000010);
    cyc(10);
    chk("dis_req", 32'(nreq), 0);
    chk("dis_gnt", 32'(pw_gnt), 0);
    csr_chk("dis_ctrl", CSR_CTRL, 0);
    end_txn();

    csr_wr(CSR_CTRL, 1);
    cmd(8'hF8, 24'h000010);
    cyc(10);
    chk("bad_req", 32'(nreq), 0);
    chk("bad_gnt", 32'(pw_gnt), 0);
    csr_chk("bad_ctrl", CSR_CTRL, 1);
    end_txn();

    csr_wr(CSR_BLEN, 2);
    cmd(8'hF9, 24'h000010);
    chk("b_gnt", 32'(pw_gnt), 1);
    wait_req(2);
    cyc(10);
    chk("b_addr0", req_addr[0], 32'h10);
    chk("b_len0", 32'(req_len[0]), 1);
    chk("b_addr1", req_addr[1], 32'h12);
    rd_byte("b0", 8'h34);
    rd_byte("b1", 8'h12);
    rd_byte("b2", 8'hCD);
    rd_byte("b3", 8'hAB);
    end_txn();
    chk("b_gnt_off", 32'(pw_gnt), 0);
    cyc(40);
    csr_chk("b_ctrl", CSR_CTRL, 1);

    base = nreq;
    grant_cap = base + 2;
    cmd(8'hF9, 24'hFFFFFE);
    cyc(30);
    chk("w_addr0", req_addr[base], 32'hFFFFFE);
    chk("w_addr1", req_addr[base+1], 32'h0);
    chk("w_cnt", 32'(nreq), 32'(base + 2));
    chk("w_hold_v", 32'(mi.mi_valid), 1);
    chk("w_hold_a", mi.mi_addr, 32'h2);
    chk("w_hold_l", 32'(mi.mi_len), 1);
    csr_chk("w_reg2", CSR_ADDR, 32'h2);
    rd_byte("w0", 8'hFE);
    rd_byte("w1", 8'h0E);
    rd_byte("w2", 8'hFF);
    rd_byte("w3", 8'h0F);
    rd_byte("w4", 8'h00);
    rd_byte("w5", 8'h10);
    csr_chk("w_ctrl", CSR_CTRL, 3);
    grant_cap = 1000000;
    end_txn();
    cyc(30);
    csr_chk("w_idle", CSR_CTRL, 1);

    base = nreq;
    grant_cap = base;
    cmd(8'hF9, 24'h000100);
    cyc(5);
    rd_byte("u0", 8'h00);
    csr_chk("u_set", CSR_CTRL, 7);
    csr_wr(CSR_CTRL, 4);
    csr_chk("u_clr", CSR_CTRL, 2);
    csr_wr(CSR_CTRL, 1);
    grant_cap = 1000000;
    end_txn();
    cyc(30);
    csr_chk("u_idle", CSR_CTRL, 1);

    csr_wr(CSR_BLEN, 8);
    gap = 3;
    base = nreq;
    wbase = nwords;
    cmd(8'hF9, 24'h000020);
    wait_words(wbase + 2);
    end_txn();
    chk("a_gnt", 32'(pw_gnt), 0);
    csr_chk("a_drain", CSR_CTRL, 3);
    chk("a_addr", req_addr[base], 32'h20);
    chk("a_len", 32'(req_len[base]), 7);
    wait_words(wbase + 8);
    cyc(3);
    csr_chk("a_idle", CSR_CTRL, 1);
    gap = 0;
    cmd(8'hF9, 24'h000010);
    chk("n_gnt", 32'(pw_gnt), 1);
    wait_req(base + 2);
    cyc(15);
    chk("n_addr", req_addr[base+1], 32'h10);
    rd_byte("n0", 8'h34);
    rd_byte("n1", 8'h12);
    rd_byte("n2", 8'hCD);
    rd_byte("n3", 8'hAB);
    end_txn();
    cyc(40);
    csr_chk("n_idle", CSR_CTRL, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
